// File: rtl/aes_loader_pkg.sv
// Shared types for the AES stream loader: FSM states, mode encodings, key length lookup.
// No logic of its own; imported by the loader and its timer.
// No flow control here; valid/ready lives in the top module.
package aes_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEY  = 2'd1,
        DATA = 2'd2,
        RUN  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_128 = 2'b00;
    localparam logic [1:0] MODE_192 = 2'b01;
    localparam logic [1:0] MODE_256 = 2'b10;

    // Both 2'b10 and 2'b11 select AES-256.
    function automatic logic [5:0] key_bytes(input logic [1:0] mode);
        case (mode)
            MODE_128: key_bytes = 6'd16;
            MODE_192: key_bytes = 6'd24;
            default:  key_bytes = 6'd32;
        endcase
    endfunction

endpackage

// File: rtl/aes_load_timer.sv
// Idle-cycle watchdog for a partially loaded block; expire is combinational from the count.
// Latency: expire asserts in the TIMEOUT_CYC-th consecutive enabled cycle without a kick.
// No backpressure; TIMEOUT_CYC=0 disables expiry entirely.
module aes_load_timer
    import aes_loader_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000000
)(
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic kick,
    output logic expire
);

    localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TW-1:0] LAST = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;

    logic [TW-1:0] idle_cnt;

    assign expire = (TIMEOUT_CYC != 0) && enable && !kick && (idle_cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt <= '0;
        end else if (!enable || kick || expire) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/aes_stream_loader.sv
// Byte-serial loader: key bytes for the latched mode, then one plaintext block, then an AES start pulse.
// Latency: aes_start is high in the cycle after the last data byte is accepted.
// Backpressure: byte_ready drops for the whole AES run and during clear.
module aes_stream_loader
    import aes_loader_pkg::*;
#(
    parameter int DATA_BYTES    = 16,
    parameter int MAX_KEY_BYTES = 32,
    parameter int TIMEOUT_CYC   = 1000000
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 mode_in,
    input  logic                       clear,
    input  logic [7:0]                 byte_in,
    input  logic                       byte_valid,
    output logic                       byte_ready,
    input  logic                       aes_flag,
    output logic [1:0]                 mode_out,
    output logic [8*MAX_KEY_BYTES-1:0] key_out,
    output logic [8*DATA_BYTES-1:0]    data_out,
    output logic                       aes_start,
    output logic                       busy,
    output logic                       done_pulse,
    output logic                       err_timeout
);

    state_t     state;
    logic [5:0] cnt;
    logic [5:0] key_len;
    logic       aes_flag_q;
    logic       rdy_en;
    logic       accept;
    logic       expire;

    // rdy_en keeps byte_ready low until the first clock after reset release.
    assign byte_ready = rdy_en && (state != RUN) && !clear;
    assign accept     = byte_valid && byte_ready;
    assign busy       = (state == RUN);
    assign key_len    = key_bytes(mode_out);

    aes_load_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .enable ((state == KEY) || (state == DATA)),
        .kick   (accept),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            key_out     <= '0;
            data_out    <= '0;
            mode_out    <= MODE_128;
            aes_flag_q  <= 1'b0;
            rdy_en      <= 1'b0;
            aes_start   <= 1'b0;
            done_pulse  <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            rdy_en      <= 1'b1;
            aes_flag_q  <= aes_flag;
            aes_start   <= 1'b0;
            done_pulse  <= 1'b0;
            err_timeout <= 1'b0;
            if (clear) begin
                state    <= IDLE;
                cnt      <= '0;
                key_out  <= '0;
                data_out <= '0;
            end else if (expire) begin
                err_timeout <= 1'b1;
                state       <= IDLE;
                cnt         <= '0;
                key_out     <= '0;
                data_out    <= '0;
            end else begin
                case (state)
                    IDLE: if (accept) begin
                        mode_out <= mode_in;
                        key_out  <= {byte_in, {(8*MAX_KEY_BYTES-8){1'b0}}};
                        data_out <= '0;
                        cnt      <= 6'd1;
                        state    <= KEY;
                    end
                    KEY: if (accept) begin
                        for (int i = 0; i < MAX_KEY_BYTES; i++)
                            if (cnt == 6'(i)) key_out[8*(MAX_KEY_BYTES-i)-1 -: 8] <= byte_in;
                        if (cnt == key_len - 6'd1) begin
                            cnt   <= '0;
                            state <= DATA;
                        end else begin
                            cnt <= cnt + 6'd1;
                        end
                    end
                    DATA: if (accept) begin
                        for (int i = 0; i < DATA_BYTES; i++)
                            if (cnt == 6'(i)) data_out[8*(DATA_BYTES-i)-1 -: 8] <= byte_in;
                        if (cnt == 6'(DATA_BYTES - 1)) begin
                            cnt       <= '0;
                            aes_start <= 1'b1;
                            state     <= RUN;
                        end else begin
                            cnt <= cnt + 6'd1;
                        end
                    end
                    RUN: begin
                        // aes_start marks the entry cycle; a flag edge there is not trusted.
                        if (!aes_start && aes_flag && !aes_flag_q) begin
                            done_pulse <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_stream_loader.sv
// Directed bench for aes_stream_loader: AES-128/192/256 loads, timeout, clear and async reset.
module tb_aes_stream_loader;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   mode_in;
    logic         clear;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_ready;
    logic         aes_flag;
    logic [1:0]   mode_out;
    logic [255:0] key_out;
    logic [127:0] data_out;
    logic         aes_start;
    logic         busy;
    logic         done_pulse;
    logic         err_timeout;

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [191:0] KEY192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] DATA_A = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] DATA_B = 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf;
    localparam logic [255:0] KEY_C  = {128'h101112131415161718191a1b1c1d1e1f, 128'h0};
    localparam logic [127:0] DATA_C = 128'h202122232425262728292a2b2c2d2e2f;

    aes_stream_loader #(
        .DATA_BYTES    (16),
        .MAX_KEY_BYTES (32),
        .TIMEOUT_CYC   (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mode_in     (mode_in),
        .clear       (clear),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .aes_flag    (aes_flag),
        .mode_out    (mode_out),
        .key_out     (key_out),
        .data_out    (data_out),
        .aes_start   (aes_start),
        .busy        (busy),
        .done_pulse  (done_pulse),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; clear = 1'b0; byte_valid = 1'b0; aes_flag = 1'b0;
        mode_in = 2'b00; byte_in = 8'h00;
        #12;
        total_cnt++; if ({byte_ready, aes_start, busy, done_pulse, err_timeout} !== 5'b0)
            $display("FAIL rst_ctrl got=%b exp=00000", {byte_ready, aes_start, busy, done_pulse, err_timeout}); else pass_cnt++;
        total_cnt++; if (key_out !== 256'h0 || data_out !== 128'h0 || mode_out !== 2'b00)
            $display("FAIL rst_data key=%h data=%h mode=%b exp=all zero", key_out, data_out, mode_out); else pass_cnt++;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        total_cnt++; if (byte_ready !== 1'b0)
            $display("FAIL rst_ready_release got=%b exp=0", byte_ready); else pass_cnt++;
        tick();
        total_cnt++; if (byte_ready !== 1'b1)
            $display("FAIL rst_ready_first_clk got=%b exp=1", byte_ready); else pass_cnt++;
    endtask

    task automatic test_aes128();
        mode_in = 2'b00;
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        for (int i = 0; i < 15; i++) send_byte(8'(i * 17));
        total_cnt++; if (aes_start !== 1'b0)
            $display("FAIL a128_start_early got=%b exp=0", aes_start); else pass_cnt++;
        send_byte(8'hff);
        total_cnt++; if ({aes_start, busy, byte_ready} !== 3'b110)
            $display("FAIL a128_start got=%b exp=110", {aes_start, busy, byte_ready}); else pass_cnt++;
        total_cnt++; if (key_out !== KEY128)
            $display("FAIL a128_key got=%h exp=%h", key_out, KEY128); else pass_cnt++;
        total_cnt++; if (data_out !== DATA_A || mode_out !== 2'b00)
            $display("FAIL a128_data got=%h/%b exp=%h/00", data_out, mode_out, DATA_A); else pass_cnt++;
        byte_in = 8'h55; byte_valid = 1'b1;
        tick();
        total_cnt++; if ({aes_start, busy, byte_ready} !== 3'b010 || data_out !== DATA_A)
            $display("FAIL a128_run_hold got=%b/%h exp=010/%h", {aes_start, busy, byte_ready}, data_out, DATA_A); else pass_cnt++;
        repeat (3) tick();
        byte_valid = 1'b0;
        aes_flag = 1'b1;
        tick();
        total_cnt++; if ({done_pulse, busy, byte_ready} !== 3'b101)
            $display("FAIL a128_done got=%b exp=101", {done_pulse, busy, byte_ready}); else pass_cnt++;
        tick();
        total_cnt++; if (done_pulse !== 1'b0 || key_out !== KEY128 || data_out !== DATA_A)
            $display("FAIL a128_after_done pulse=%b key=%h data=%h", done_pulse, key_out, data_out); else pass_cnt++;
        aes_flag = 1'b0;
        tick();
    endtask

    task automatic test_aes256_gaps();
        int early = 0;
        mode_in = 2'b10;
        for (int i = 0; i < 32; i++) begin
            send_byte(8'(i));
            if (i == 0) mode_in = 2'b00;
            if (aes_start) early++;
            if (i % 5 == 2) repeat (3) begin tick(); if (aes_start) early++; end
        end
        for (int i = 0; i < 15; i++) begin
            send_byte(8'(i * 17));
            if (aes_start) early++;
            if (i % 4 == 1) repeat (2) begin tick(); if (aes_start) early++; end
        end
        send_byte(8'hff);
        total_cnt++; if (early !== 0)
            $display("FAIL a256_start_early got=%0d exp=0", early); else pass_cnt++;
        total_cnt++; if (aes_start !== 1'b1 || mode_out !== 2'b10)
            $display("FAIL a256_start_mode got=%b/%b exp=1/10", aes_start, mode_out); else pass_cnt++;
        total_cnt++; if (key_out !== KEY256 || data_out !== DATA_A)
            $display("FAIL a256_key_data got=%h/%h exp=%h/%h", key_out, data_out, KEY256, DATA_A); else pass_cnt++;
        tick();
        aes_flag = 1'b1;
        tick();
        total_cnt++; if (done_pulse !== 1'b1)
            $display("FAIL a256_done got=%b exp=1", done_pulse); else pass_cnt++;
        aes_flag = 1'b0;
        tick();
    endtask

    task automatic test_aes192_boundary();
        int hits = 0;
        mode_in = 2'b01;
        for (int i = 0; i < 24; i++) send_byte(8'(i));
        send_byte(8'ha0);
        total_cnt++; if (data_out[127:120] !== 8'ha0 || key_out[63:0] !== 64'h0)
            $display("FAIL a192_boundary got=%h/%h exp=a0/0", data_out[127:120], key_out[63:0]); else pass_cnt++;
        total_cnt++; if (key_out[255:64] !== KEY192)
            $display("FAIL a192_key got=%h exp=%h", key_out[255:64], KEY192); else pass_cnt++;
        aes_flag = 1'b1;
        for (int i = 1; i < 16; i++) send_byte(8'(8'ha0 + i));
        total_cnt++; if (aes_start !== 1'b1 || mode_out !== 2'b01 || data_out !== DATA_B)
            $display("FAIL a192_start got=%b/%b/%h exp=1/01/%h", aes_start, mode_out, data_out, DATA_B); else pass_cnt++;
        repeat (5) begin tick(); if (done_pulse) hits++; end
        aes_flag = 1'b0;
        repeat (2) begin tick(); if (done_pulse) hits++; end
        total_cnt++; if (hits !== 0 || busy !== 1'b1)
            $display("FAIL a192_stale_flag pulses=%0d busy=%b exp=0/1", hits, busy); else pass_cnt++;
        aes_flag = 1'b1;
        tick();
        total_cnt++; if (done_pulse !== 1'b1 || busy !== 1'b0)
            $display("FAIL a192_done got=%b/%b exp=1/0", done_pulse, busy); else pass_cnt++;
        aes_flag = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int bad = 0;
        mode_in = 2'b00;
        for (int i = 0; i < 5; i++) send_byte(8'(8'hc0 + i));
        total_cnt++; if (key_out[255:216] !== 40'hc0c1c2c3c4)
            $display("FAIL to_partial got=%h exp=c0c1c2c3c4", key_out[255:216]); else pass_cnt++;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (err_timeout !== (k == 8)) bad++;
        end
        total_cnt++; if (bad !== 0)
            $display("FAIL to_pulse_timing bad_cycles=%0d exp=0", bad); else pass_cnt++;
        total_cnt++; if (key_out !== 256'h0 || data_out !== 128'h0 || byte_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL to_abort key=%h data=%h rdy=%b busy=%b", key_out, data_out, byte_ready, busy); else pass_cnt++;
        tick();
        total_cnt++; if (err_timeout !== 1'b0)
            $display("FAIL to_single_pulse got=%b exp=0", err_timeout); else pass_cnt++;
        mode_in = 2'b01;
        send_byte(8'h5a);
        total_cnt++; if (mode_out !== 2'b01 || key_out !== {8'h5a, 248'h0})
            $display("FAIL to_restart got=%b/%h exp=01/5a00..", mode_out, key_out); else pass_cnt++;
    endtask

    task automatic test_clear_and_reset();
        for (int i = 1; i < 9; i++) send_byte(8'(i));
        byte_in = 8'h99; byte_valid = 1'b1; clear = 1'b1;
        #1;
        total_cnt++; if (byte_ready !== 1'b0)
            $display("FAIL clr_ready got=%b exp=0", byte_ready); else pass_cnt++;
        tick();
        clear = 1'b0; byte_valid = 1'b0;
        total_cnt++; if (key_out !== 256'h0 || data_out !== 128'h0 || mode_out !== 2'b01)
            $display("FAIL clr_state key=%h data=%h mode=%b exp=0/0/01", key_out, data_out, mode_out); else pass_cnt++;
        total_cnt++; if ({aes_start, done_pulse, err_timeout} !== 3'b000)
            $display("FAIL clr_pulses got=%b exp=000", {aes_start, done_pulse, err_timeout}); else pass_cnt++;
        mode_in = 2'b00;
        for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i));
        for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i));
        total_cnt++; if (aes_start !== 1'b1 || key_out !== KEY_C || data_out !== DATA_C)
            $display("FAIL clr_reload got=%b/%h/%h exp=1/%h/%h", aes_start, key_out, data_out, KEY_C, DATA_C); else pass_cnt++;
        #2 reset = 1'b0;
        #1;
        total_cnt++; if ({aes_start, busy, byte_ready, done_pulse, err_timeout} !== 5'b0)
            $display("FAIL rst_run_ctrl got=%b exp=00000", {aes_start, busy, byte_ready, done_pulse, err_timeout}); else pass_cnt++;
        total_cnt++; if (key_out !== 256'h0 || data_out !== 128'h0 || mode_out !== 2'b00)
            $display("FAIL rst_run_data key=%h data=%h mode=%b exp=0", key_out, data_out, mode_out); else pass_cnt++;
        #2 reset = 1'b1;
        #1;
        total_cnt++; if (byte_ready !== 1'b0)
            $display("FAIL rst_run_release got=%b exp=0", byte_ready); else pass_cnt++;
        tick();
        total_cnt++; if (byte_ready !== 1'b1 || done_pulse !== 1'b0 || busy !== 1'b0)
            $display("FAIL rst_run_recover got=%b/%b/%b exp=1/0/0", byte_ready, done_pulse, busy); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_aes128();
        test_aes256_gaps();
        test_aes192_boundary();
        test_timeout();
        test_clear_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete, passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule

// File: doc/aes_stream_loader.md
Name: aes_stream_loader

Overview:
- Upstream feeder for the multi-mode AES core. It replaces hard-wired plaintext and key constants with a byte-serial valid/ready input.
- Collects key bytes for the selected mode, then 16 plaintext bytes, then presents a left-aligned 256-bit key and a 128-bit block with a start pulse.
- Holds its outputs until the AES done flag rises, then returns to idle.
- Drives the AES mode select, so the downstream key slice is key_out[255-:16*8/24*8/32*8].

Parameters:
- DATA_BYTES, 16, plaintext bytes per block; fixed by AES and not to be overridden.
- MAX_KEY_BYTES, 32, width of key_out in bytes.
- TIMEOUT_CYC, 1000000, maximum cycles between accepted bytes during a partial load; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- mode_in  input  2  00=AES-128, 01=AES-192, 10/11=AES-256; sampled only on the first key byte.
- clear  input  1  synchronous abort, highest priority after reset.
- byte_in  input  8  stream byte; first byte is the MSB.
- byte_valid  input  1  byte_in valid.
- byte_ready  output  1  loader can accept.
- aes_flag  input  1  done flag from the selected AES core.
- mode_out  output  2  latched mode, drives the AES controller select.
- key_out  output  256  key, left-aligned; unused low bytes are zero.
- data_out  output  128  plaintext block.
- aes_start  output  1  one-cycle pulse, block ready.
- busy  output  1  high in RUN.
- done_pulse  output  1  one-cycle pulse on completion.
- err_timeout  output  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (reset=0, async): state=IDLE, cnt=0, key_out=0, data_out=0, mode_out=00. byte_ready, aes_start, busy, done_pulse and err_timeout are all 0 until the first clock after release; byte_ready then goes to 1.
- Accept = byte_valid & byte_ready.
- byte_ready = (state!=RUN) & ~clear.
- key_len = 16/24/32 for mode_out 00/01/1x.
- States:
  - IDLE: on accept, latch mode_out<=mode_in, write key byte 0 to key_out[255:248], zero the rest of key_out and data_out, cnt<=1, go to KEY. If key_len is reached this is impossible, since min key_len is 16.
  - KEY: on accept, key_out[255-8*cnt -: 8]<=byte_in. If cnt==key_len-1, then cnt<=0 and go to DATA; else cnt++.
  - DATA: on accept, data_out[127-8*cnt -: 8]<=byte_in. If cnt==15, go to RUN; else cnt++.
  - RUN: aes_start=1 in the first RUN cycle only; busy=1. aes_flag_q is the registered aes_flag. Rising edge (aes_flag & ~aes_flag_q) detected in any RUN cycle after the first: done_pulse=1 next cycle, go to IDLE, key_out/data_out/mode_out hold. A flag already high on RUN entry is ignored until it falls and rises again.
- Latency: last data byte accepted at edge N; aes_start high during cycle N+1.
- mode_in changes after the first key byte are ignored until the next IDLE.
- Timeout: idle counter increments in KEY/DATA on cycles without an accept and clears on accept. When TIMEOUT_CYC!=0 and counter==TIMEOUT_CYC-1:
  - err_timeout pulses;
  - go to IDLE;
  - key_out=0, data_out=0, cnt=0.
  - The counter is inactive in IDLE/RUN.
- clear=1, any state: next state IDLE, cnt=0, key_out=0, data_out=0, mode_out holds. No byte is accepted that cycle (byte_ready=0). It suppresses a coincident done_pulse and err_timeout.
- Reset mid-load or mid-RUN: immediate return to reset values; no pulses are generated.
- Widths: cnt is 6 bits; the timeout counter is $clog2(TIMEOUT_CYC+1) bits, minimum 1.

Decomposition:
- Package aes_loader_pkg holds:
  - state enum IDLE/KEY/DATA/RUN (2-bit);
  - mode constants MODE_128=2'b00, MODE_192=2'b01, MODE_256=2'b10;
  - function key_bytes(mode) returning 16/24/32.
- One sub-module, aes_load_timer: the idle/timeout counter with inputs enable, kick and TIMEOUT_CYC, and output expire.

Test Plan:
- AES-128: mode_in=00; stream 000102..0f, then 00112233..ff at one byte per cycle, no stalls.
  - Required: key_out = 256'h000102..0f followed by 128'h0; data_out = 128'h00112233445566778899aabbccddeeff.
  - aes_start pulses exactly 1 cycle after the 32nd accept; mode_out=00; byte_ready=0 until aes_flag rises, then done_pulse and byte_ready=1.
- AES-256 with valid gaps: mode_in=10; stream 00..1f then 00112233..ff with random byte_valid bubbles.
  - Required: key_out=256'h000102..1f; aes_start after the 48th accept.
  - mode_in toggled to 00 mid-load leaves mode_out=10.
- AES-192 boundary: mode_in=01; stream 24 key bytes 00..17.
  - Required: byte 24 lands in data_out[127:120] and key_out[63:0]=0.
  - aes_flag held high from before RUN entry produces no done_pulse until it drops and rises.
- Timeout: TIMEOUT_CYC=8; send 5 bytes, then idle.
  - Required: err_timeout pulses on the 8th idle cycle; state IDLE; key_out=0.
  - A new first byte restarts cleanly.
- Clear/reset priority: assert clear together with byte_valid on the 10th byte.
  - Required: byte not accepted, no pulses, cnt=0.
  - Pull reset low during RUN: busy=0 and aes_start=0 immediately (asynchronous), all outputs at reset values.
